pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_skid_buffer.sv | 102 ++++++++++
 tb/tb_pipe_skid_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry pipeline skid buffer between fetch and decode.
// The main entry drives registered outputs and the skid entry absorbs one beat of backpressure.
module pipe_skid_buffer #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INST_W   = 16,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pcAddIn,
    input  logic [INST_W-1:0] instIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pcAddOut,
    output logic [INST_W-1:0] instOut,
    output logic [1:0]        occupancy
);

    logic              mainValid;
    logic              skidValid;
    logic [ADDR_W-1:0] skidPc;
    logic [INST_W-1:0] skidInst;

    logic              mainValidNext;
    logic              skidValidNext;
    logic [ADDR_W-1:0] pcOutNext;
    logic [INST_W-1:0] instOutNext;
    logic [ADDR_W-1:0] skidPcNext;
    logic [INST_W-1:0] skidInstNext;

    logic push;
    logic pop;

    // Handshake status comes only from registered valid bits.
    assign in_ready  = ~skidValid;
    assign out_valid = mainValid;
    assign occupancy = 2'(mainValid) + 2'(skidValid);

    assign push = in_valid & ~skidValid;
    assign pop  = mainValid & out_ready;

    // Next-state selection; flush overrides any push or pop.
    always_comb begin
        mainValidNext = mainValid;
        skidValidNext = skidValid;
        pcOutNext     = pcAddOut;
        instOutNext   = instOut;
        skidPcNext    = skidPc;
        skidInstNext  = skidInst;

        if (flush) begin
            mainValidNext = 1'b0;
            skidValidNext = 1'b0;
            instOutNext   = NOP_INST;
        end else if (!mainValid) begin
            if (push) begin
                mainValidNext = 1'b1;
                pcOutNext     = pcAddIn;
                instOutNext   = instIn;
            end
        end else if (pop) begin
            if (skidValid) begin
                skidValidNext = 1'b0;
                pcOutNext     = skidPc;
                instOutNext   = skidInst;
            end else if (push) begin
                pcOutNext     = pcAddIn;
                instOutNext   = instIn;
            end else begin
                // Drained: the PC is left in place, only the instruction becomes a bubble.
                mainValidNext = 1'b0;
                instOutNext   = NOP_INST;
            end
        end else if (push) begin
            skidValidNext = 1'b1;
            skidPcNext    = pcAddIn;
            skidInstNext  = instIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            pcAddOut  <= '0;
            instOut   <= NOP_INST;
            skidPc    <= '0;
            skidInst  <= '0;
        end else begin
            mainValid <= mainValidNext;
            skidValid <= skidValidNext;
            pcAddOut  <= pcOutNext;
            instOut   <= instOutNext;
            skidPc    <= skidPcNext;
            skidInst  <= skidInstNext;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed vector table, async reset cases,
// randomized traffic against a queue model, and a 32-bit parameterised instance.
module tb_pipe_skid_buffer;

    logic        clk;
    logic        rst_n;

    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [15:0] pcIn;
    logic [15:0] instInS;
    logic        outValid;
    logic        outReady;
    logic [15:0] pcOut;
    logic [15:0] instOutS;
    logic [1:0]  occ;

    logic        flush32;
    logic        inValid32;
    logic        inReady32;
    logic [31:0] pcIn32;
    logic [31:0] instIn32;
    logic        outValid32;
    logic        outReady32;
    logic [31:0] pcOut32;
    logic [31:0] instOut32;
    logic [1:0]  occ32;

    int tests;
    int fails;

    pipe_skid_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady),
        .pcAddIn(pcIn), .instIn(instInS),
        .out_valid(outValid), .out_ready(outReady),
        .pcAddOut(pcOut), .instOut(instOutS), .occupancy(occ)
    );

    pipe_skid_buffer #(.ADDR_W(32), .INST_W(32), .NOP_INST(32'h0000_0013)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32),
        .in_valid(inValid32), .in_ready(inReady32),
        .pcAddIn(pcIn32), .instIn(instIn32),
        .out_valid(outValid32), .out_ready(outReady32),
        .pcAddOut(pcOut32), .instOut(instOut32), .occupancy(occ32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        inValid;
        logic        outReady;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        expValid;
        logic        expReady;
        logic [15:0] expPc;
        logic [15:0] expInst;
        logic [1:0]  expOcc;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } entry_t;

    vec_t   vecs[17];
    entry_t modelQ[$];
    logic [15:0] modelPc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic v, input logic r,
                         input logic [15:0] p, input logic [15:0] i);
        flush    = f;
        inValid  = v;
        outReady = r;
        pcIn     = p;
        instInS  = i;
    endtask

    task automatic checkAll(input string tag, input logic v, input logic rdy,
                            input logic [15:0] p, input logic [15:0] i, input logic [1:0] o);
        check({tag, ".out_valid"}, 32'(outValid), 32'(v));
        check({tag, ".in_ready"},  32'(inReady),  32'(rdy));
        check({tag, ".pcAddOut"},  32'(pcOut),    32'(p));
        check({tag, ".instOut"},   32'(instOutS), 32'(i));
        check({tag, ".occupancy"}, 32'(occ),      32'(o));
    endtask

    function automatic vec_t mk(input logic f, input logic v, input logic r,
                                input logic [15:0] p, input logic [15:0] i,
                                input logic ev, input logic er, input logic [15:0] ep,
                                input logic [15:0] ei, input logic [1:0] eo);
        vec_t t;
        t.flush = f; t.inValid = v; t.outReady = r; t.pc = p; t.inst = i;
        t.expValid = ev; t.expReady = er; t.expPc = ep; t.expInst = ei; t.expOcc = eo;
        return t;
    endfunction

    // Queue model: the head is the output entry, capacity two.
    task automatic modelStep(input logic f, input logic v, input logic r,
                             input logic [15:0] p, input logic [15:0] i);
        int n;
        entry_t e;
        n = modelQ.size();
        if (f) begin
            modelQ.delete();
        end else begin
            if (n > 0 && r) void'(modelQ.pop_front());
            if (v && n < 2) begin
                e.pc = p;
                e.inst = i;
                modelQ.push_back(e);
            end
        end
        if (modelQ.size() > 0) modelPc = modelQ[0].pc;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        flush32 = 1'b0; inValid32 = 1'b0; outReady32 = 1'b0; pcIn32 = '0; instIn32 = '0;

        // Async reset seen before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        checkAll("reset", 1'b0, 1'b1, 16'h0, 16'h0, 2'd0);
        check("reset32.instOut", instOut32, 32'h0000_0013);
        check("reset32.out_valid", 32'(outValid32), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = mk(0, 1, 1, 16'h0002, 16'h0001, 1, 1, 16'h0002, 16'h0001, 2'd1);
        vecs[1]  = mk(0, 1, 1, 16'h0004, 16'h0002, 1, 1, 16'h0004, 16'h0002, 2'd1);
        vecs[2]  = mk(0, 1, 1, 16'h0006, 16'h0003, 1, 1, 16'h0006, 16'h0003, 2'd1);
        vecs[3]  = mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 16'h0006, 16'h0000, 2'd0);
        vecs[4]  = mk(0, 1, 0, 16'h0002, 16'h0001, 1, 1, 16'h0002, 16'h0001, 2'd1);
        vecs[5]  = mk(0, 1, 0, 16'h0004, 16'h0002, 1, 0, 16'h0002, 16'h0001, 2'd2);
        vecs[6]  = mk(0, 1, 0, 16'h0006, 16'h0003, 1, 0, 16'h0002, 16'h0001, 2'd2);
        vecs[7]  = mk(0, 1, 1, 16'h0006, 16'h0003, 1, 1, 16'h0004, 16'h0002, 2'd1);
        vecs[8]  = mk(0, 1, 1, 16'h0006, 16'h0003, 1, 1, 16'h0006, 16'h0003, 2'd1);
        vecs[9]  = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0006, 16'h0003, 2'd1);
        vecs[10] = mk(0, 1, 0, 16'h000A, 16'h0005, 1, 0, 16'h0006, 16'h0003, 2'd2);
        vecs[11] = mk(1, 1, 1, 16'h000C, 16'h0004, 0, 1, 16'h0006, 16'h0000, 2'd0);
        vecs[12] = mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 16'h0006, 16'h0000, 2'd0);
        vecs[13] = mk(0, 1, 0, 16'h0008, 16'h0007, 1, 1, 16'h0008, 16'h0007, 2'd1);
        vecs[14] = mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 16'h0008, 16'h0000, 2'd0);
        vecs[15] = mk(0, 0, 1, 16'hBEEF, 16'hDEAD, 0, 1, 16'h0008, 16'h0000, 2'd0);
        vecs[16] = mk(1, 1, 0, 16'h0010, 16'h0009, 0, 1, 16'h0008, 16'h0000, 2'd0);

        for (int k = 0; k < 17; k++) begin
            drive(vecs[k].flush, vecs[k].inValid, vecs[k].outReady, vecs[k].pc, vecs[k].inst);
            step();
            checkAll($sformatf("vec%0d", k), vecs[k].expValid, vecs[k].expReady,
                     vecs[k].expPc, vecs[k].expInst, vecs[k].expOcc);
        end

        // Reset in the middle of a backpressured transfer.
        drive(0, 1, 0, 16'h0020, 16'h0021); step();
        drive(0, 1, 0, 16'h0022, 16'h0023); step();
        check("midrst.fill", 32'(occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkAll("midrst", 1'b0, 1'b1, 16'h0, 16'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 16'h0030, 16'h0031); step();
        checkAll("postrst", 1'b1, 1'b1, 16'h0030, 16'h0031, 2'd1);
        drive(0, 0, 1, 16'h0, 16'h0); step();
        checkAll("postrst.drain", 1'b0, 1'b1, 16'h0030, 16'h0000, 2'd0);

        // Randomized traffic against the queue model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelQ.delete();
        modelPc = 16'h0;
        for (int c = 0; c < 2000; c++) begin
            logic f, v, r;
            logic [15:0] p, i;
            f = ($urandom_range(15) == 0);
            v = ($urandom_range(3) != 0);
            r = (c % 400 < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            p = 16'($urandom);
            i = 16'($urandom);
            drive(f, v, r, p, i);
            modelStep(f, v, r, p, i);
            step();
            checkAll($sformatf("rand%0d", c),
                     modelQ.size() > 0,
                     modelQ.size() < 2,
                     modelPc,
                     (modelQ.size() > 0) ? modelQ[0].inst : 16'h0000,
                     2'(modelQ.size()));
        end
        drive(0, 0, 0, 16'h0, 16'h0);

        // Full-width instance: streaming, then flush to the custom NOP.
        for (int k = 0; k < 3; k++) begin
            flush32 = 1'b0; inValid32 = 1'b1; outReady32 = 1'b1;
            pcIn32 = 32'(2 * (k + 1)) | 32'hA5A5_0000;
            instIn32 = 32'(k + 1) | 32'h5A5A_0000;
            step();
            check($sformatf("w32.stream%0d.pc", k), pcOut32, 32'(2 * (k + 1)) | 32'hA5A5_0000);
            check($sformatf("w32.stream%0d.inst", k), instOut32, 32'(k + 1) | 32'h5A5A_0000);
            check($sformatf("w32.stream%0d.occ", k), 32'(occ32), 32'd1);
            check($sformatf("w32.stream%0d.valid", k), 32'(outValid32), 32'd1);
        end
        outReady32 = 1'b0; pcIn32 = 32'h10; instIn32 = 32'h11; step();
        check("w32.fill.occ", 32'(occ32), 32'd2);
        flush32 = 1'b1; inValid32 = 1'b1; instIn32 = 32'h99; step();
        check("w32.flush.inst", instOut32, 32'h0000_0013);
        check("w32.flush.occ", 32'(occ32), 32'd0);
        check("w32.flush.valid", 32'(outValid32), 32'd0);
        flush32 = 1'b0; inValid32 = 1'b0; step();
        check("w32.idle.inst", instOut32, 32'h0000_0013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
